// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - Shared types and helpers for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } arb_owner_t;

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit register.
  function automatic int wd_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Fetch, load/store and memory port bundle for the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [BE_W-1:0]   ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // slave is the arbiter's view; master is the requesters plus the memory.
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - Combinational two-way round-robin select.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_ls,
  input  arb_owner_t last_owner,
  output logic       pick_if,
  output logic       pick_ls
);

  always_comb begin
    pick_if = 1'b0;
    pick_ls = 1'b0;
    if (req_if && req_ls) begin
      // On a tie the side that did not win last time goes first.
      if (last_owner == OWN_IF) begin
        pick_ls = 1'b1;
      end else begin
        pick_if = 1'b1;
      end
    end else begin
      pick_if = req_if;
      pick_ls = req_ls;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Round-robin arbiter sharing one memory port between fetch and load/store.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int          BE_W      = DATA_W / 8;
  localparam int          WD_W      = wd_width(TIMEOUT_CYCLES);
  localparam logic [31:0] TIMEOUT_U = 32'(TIMEOUT_CYCLES);

  arb_state_t        state;
  arb_owner_t        owner;
  arb_owner_t        last_owner;
  logic [WD_W-1:0]   wd;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic              if_rvalid_r, if_err_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic              ls_rvalid_r, ls_err_r;
  logic [DATA_W-1:0] ls_rdata_r;

  logic              pick_if, pick_ls;
  logic              idle, mem_done, timeout;

  mem_port_arbiter_rr_pick2 u_pick (
    .req_if     (bus.if_req),
    .req_ls     (bus.ls_req),
    .last_owner (last_owner),
    .pick_if    (pick_if),
    .pick_ls    (pick_ls)
  );

  assign idle     = (state == ARB_IDLE);
  assign mem_done = ((state == ARB_REQ) && bus.mem_ready && bus.mem_rvalid) ||
                    ((state == ARB_RESP) && bus.mem_rvalid);
  // The response is registered, so fire one cycle early to land exactly
  // TIMEOUT_CYCLES after the grant.
  assign timeout  = (TIMEOUT_CYCLES > 0) && !idle && ((32'(wd) + 32'd2) >= TIMEOUT_U);

  assign bus.if_gnt    = rst_n && idle && pick_if;
  assign bus.ls_gnt    = rst_n && idle && pick_ls;
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.if_err    = if_err_r;
  assign bus.ls_rvalid = ls_rvalid_r;
  assign bus.ls_rdata  = ls_rdata_r;
  assign bus.ls_err    = ls_err_r;
  assign bus.mem_req   = (state == ARB_REQ);
  assign bus.mem_we    = cap_we;
  assign bus.mem_addr  = cap_addr;
  assign bus.mem_wdata = cap_wdata;
  assign bus.mem_be    = cap_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      owner       <= OWN_NONE;
      last_owner  <= OWN_LS;
      wd          <= '0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_be      <= '0;
      if_rvalid_r <= 1'b0;
      if_err_r    <= 1'b0;
      if_rdata_r  <= '0;
      ls_rvalid_r <= 1'b0;
      ls_err_r    <= 1'b0;
      ls_rdata_r  <= '0;
    end else begin
      if_rvalid_r <= 1'b0;
      if_err_r    <= 1'b0;
      if_rdata_r  <= '0;
      ls_rvalid_r <= 1'b0;
      ls_err_r    <= 1'b0;
      ls_rdata_r  <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_if || pick_ls) begin
            owner      <= pick_if ? OWN_IF : OWN_LS;
            last_owner <= pick_if ? OWN_IF : OWN_LS;
            state      <= ARB_REQ;
            wd         <= '0;
            cap_we     <= pick_ls && bus.ls_we;
            cap_addr   <= pick_if ? bus.if_addr : bus.ls_addr;
            cap_wdata  <= pick_if ? '0 : bus.ls_wdata;
            cap_be     <= pick_if ? '1 : bus.ls_be;
          end
        end
        ARB_REQ, ARB_RESP: begin
          if (wd != '1) begin
            wd <= wd + WD_W'(1);
          end
          if (mem_done || timeout) begin
            // A real response wins over a watchdog expiring in the same cycle.
            if (owner == OWN_IF) begin
              if_rvalid_r <= 1'b1;
              if_err_r    <= !mem_done;
              if_rdata_r  <= mem_done ? bus.mem_rdata : '0;
            end
            if (owner == OWN_LS) begin
              ls_rvalid_r <= 1'b1;
              ls_err_r    <= !mem_done;
              ls_rdata_r  <= mem_done ? bus.mem_rdata : '0;
            end
            owner <= OWN_NONE;
            state <= ARB_IDLE;
          end else if ((state == ARB_REQ) && bus.mem_ready) begin
            state <= ARB_RESP;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
